// File: rtl/vc_egress_arbiter_if.sv
// Bundles the VC FIFO read side and the destination FIFO write side of the
// egress arbiter. The arbiter connects through master; the FIFO environment
// connects through slave.
interface vc_egress_arbiter_if #(
    parameter int data_width = 6
);
    logic [data_width-1:0] data_vc0;
    logic [data_width-1:0] data_vc1;
    logic                  empty_vc0;
    logic                  empty_vc1;
    logic                  pause_d0;
    logic                  pause_d1;
    logic                  pop_vc0;
    logic                  pop_vc1;
    logic [data_width-1:0] data_out_d0;
    logic [data_width-1:0] data_out_d1;
    logic                  push_d0;
    logic                  push_d1;

    modport master (
        input  data_vc0, data_vc1, empty_vc0, empty_vc1, pause_d0, pause_d1,
        output pop_vc0, pop_vc1, data_out_d0, data_out_d1, push_d0, push_d1
    );

    modport slave (
        output data_vc0, data_vc1, empty_vc0, empty_vc1, pause_d0, pause_d1,
        input  pop_vc0, pop_vc1, data_out_d0, data_out_d1, push_d0, push_d1
    );
endinterface

// File: rtl/vc_egress_arbiter.sv
// Two-VC egress arbiter: weighted pick between VC0 and VC1 FIFOs, two-cycle
// read pipeline, routing of each popped word to one of two destination FIFOs
// by bit [data_width-2]. Destination pause blocks new pops only; words
// already popped still drain, since downstream reserves room for them.
module vc_egress_arbiter #(
    parameter int data_width = 6,
    parameter int vc0_weight = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    vc_egress_arbiter_if.master    bus,
    output logic [1:0]             state,
    output logic                   idle_out
);
    localparam int streak_w = $clog2(vc0_weight + 1);
    localparam logic [streak_w-1:0] streak_max = streak_w'(vc0_weight);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        PAUSE  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [streak_w-1:0]   streak_q, streak_d;
    logic                  s1_valid;
    logic                  s1_vc;
    logic [data_width-1:0] s1_data;
    logic                  s1_sel;
    logic                  any_pause;
    logic                  any_ready;
    logic                  pop_ok;
    logic                  grant_vc0;
    logic                  grant_vc1;
    logic                  pop0, pop1;
    logic                  push0_q, push1_q;
    logic [data_width-1:0] dout0_q, dout1_q;

    // Arbitration, pop strobes and streak update; pops are held off in reset.
    always_comb begin
        any_pause = bus.pause_d0 | bus.pause_d1;
        any_ready = ~bus.empty_vc0 | ~bus.empty_vc1;
        pop_ok    = reset && (state_q != PAUSE) && !any_pause;
        grant_vc0 = ~bus.empty_vc0 && (bus.empty_vc1 || (streak_q != streak_max));
        grant_vc1 = ~bus.empty_vc1 && !grant_vc0;
        pop0      = pop_ok && grant_vc0;
        pop1      = pop_ok && grant_vc1;
        streak_d  = streak_q;
        if (pop1) begin
            streak_d = '0;
        end else if (pop0 && (streak_q != streak_max)) begin
            streak_d = streak_q + streak_w'(1);
        end
    end

    // Next-state logic; a pause always wins over starting or continuing.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_ready && !any_pause) state_d = ACTIVE;
            ACTIVE:  if (any_pause)               state_d = PAUSE;
                     else if (!any_ready)         state_d = IDLE;
            PAUSE:   if (!any_pause)              state_d = any_ready ? ACTIVE : IDLE;
            default:                              state_d = IDLE;
        endcase
    end

    // Word popped last cycle is now on the read data of the chosen VC.
    always_comb begin
        s1_data = s1_vc ? bus.data_vc1 : bus.data_vc0;
        s1_sel  = s1_data[data_width-2];
    end

    // State, streak and read pipeline registers; reset drops in-flight words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            streak_q <= '0;
            s1_valid <= 1'b0;
            s1_vc    <= 1'b0;
            push0_q  <= 1'b0;
            push1_q  <= 1'b0;
            dout0_q  <= '0;
            dout1_q  <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            s1_valid <= pop0 | pop1;
            s1_vc    <= pop1;
            push0_q  <= s1_valid && !s1_sel;
            push1_q  <= s1_valid && s1_sel;
            if (s1_valid && !s1_sel) dout0_q <= s1_data;
            if (s1_valid && s1_sel)  dout1_q <= s1_data;
        end
    end

    assign bus.pop_vc0     = pop0;
    assign bus.pop_vc1     = pop1;
    assign bus.push_d0     = push0_q;
    assign bus.push_d1     = push1_q;
    assign bus.data_out_d0 = dout0_q;
    assign bus.data_out_d1 = dout1_q;
    assign state           = state_q;
    assign idle_out        = (state_q == IDLE) && !s1_valid && !push0_q && !push1_q;
endmodule

// File: tb/tb_vc_egress_arbiter.sv
// Directed bench for vc_egress_arbiter with a behavioural model of the two
// VC FIFOs (read data appears the cycle after a pop).
module tb_vc_egress_arbiter;
    localparam int dw = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] state;
    logic       idle_out;

    vc_egress_arbiter_if #(.data_width(dw)) bus ();

    vc_egress_arbiter #(.data_width(dw), .vc0_weight(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .state    (state),
        .idle_out (idle_out)
    );

    always #5 clk = ~clk;

    logic [dw-1:0] q0 [32];
    logic [dw-1:0] q1 [32];
    int unsigned   rd0, wr0, rd1, wr1;
    int            n_checks = 0;
    int            n_fail   = 0;

    // Grant order and push routing with both FIFOs loaded, weight 3.
    logic [1:0]    exp_pop  [10] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
    logic [1:0]    exp_push [10] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
    logic [dw-1:0] exp_data [10] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h10, 6'h03, 6'h04, 6'h05, 6'h11};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic update_empty;
        bus.empty_vc0 = (rd0 == wr0);
        bus.empty_vc1 = (rd1 == wr1);
    endtask

    task automatic load(input int vc, input logic [dw-1:0] w);
        if (vc == 0) begin q0[wr0] = w; wr0++; end
        else         begin q1[wr1] = w; wr1++; end
        update_empty;
    endtask

    // One clock: the FIFO model serves the pops seen during the cycle.
    task automatic step;
        logic p0, p1;
        p0 = bus.pop_vc0;
        p1 = bus.pop_vc1;
        @(posedge clk);
        #1;
        if (p0 && rd0 != wr0) begin bus.data_vc0 = q0[rd0]; rd0++; end
        if (p1 && rd1 != wr1) begin bus.data_vc1 = q1[rd1]; rd1++; end
        update_empty;
        #1;
    endtask

    task automatic apply_reset;
        reset = 1'b0;
        bus.pause_d0 = 1'b0;
        bus.pause_d1 = 1'b0;
        rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
        update_empty;
        step;
        check("rst_state", 32'(state), 32'd0);
        check("rst_idle",  32'(idle_out), 32'd1);
        check("rst_push",  32'({bus.push_d1, bus.push_d0}), 32'd0);
        check("rst_dout0", 32'(bus.data_out_d0), 32'd0);
        check("rst_dout1", 32'(bus.data_out_d1), 32'd0);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (!(idle_out && bus.empty_vc0 && bus.empty_vc1) && n < 60) begin
            step;
            n++;
        end
        check(tag, 32'(idle_out), 32'd1);
    endtask

    initial begin
        bus.data_vc0 = '0;
        bus.data_vc1 = '0;
        apply_reset;

        // Two VC0 words routed to different destinations.
        load(0, 6'h05);
        load(0, 6'h15);
        #1;
        check("rst_pop_gate", 32'({bus.pop_vc1, bus.pop_vc0}), 32'd0);
        reset = 1'b1;
        #1;
        check("r33_pop_c0", 32'({bus.pop_vc1, bus.pop_vc0}), 32'b01);
        step;
        check("r33_pop_c1", 32'({bus.pop_vc1, bus.pop_vc0}), 32'b01);
        step;
        check("r33_push0",  32'({bus.push_d1, bus.push_d0}), 32'b01);
        check("r33_dout0",  32'(bus.data_out_d0), 32'h05);
        check("r33_nopop",  32'({bus.pop_vc1, bus.pop_vc0}), 32'd0);
        check("r33_state1", 32'(state), 32'd1);
        check("r33_busy",   32'(idle_out), 32'd0);
        step;
        check("r33_push1",  32'({bus.push_d1, bus.push_d0}), 32'b10);
        check("r33_dout1",  32'(bus.data_out_d1), 32'h15);
        check("r33_hold0",  32'(bus.data_out_d0), 32'h05);
        check("r33_state0", 32'(state), 32'd0);
        step;
        check("r33_done",   32'({bus.push_d1, bus.push_d0}), 32'd0);
        check("r33_idle",   32'(idle_out), 32'd1);
        check("r33_hold1",  32'(bus.data_out_d1), 32'h15);

        // Weighted arbitration, both FIFOs full of 8 words.
        apply_reset;
        for (int i = 0; i < 8; i++) begin
            load(0, 6'(i));
            load(1, 6'(16 + i));
        end
        reset = 1'b1;
        #1;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("r34_pop_c%0d", c), 32'({bus.pop_vc1, bus.pop_vc0}), 32'(exp_pop[c]));
            check($sformatf("r34_push_c%0d", c), 32'({bus.push_d1, bus.push_d0}), 32'(exp_push[c]));
            if (exp_push[c] == 2'b01) check($sformatf("r34_d0_c%0d", c), 32'(bus.data_out_d0), 32'(exp_data[c]));
            if (exp_push[c] == 2'b10) check($sformatf("r34_d1_c%0d", c), 32'(bus.data_out_d1), 32'(exp_data[c]));
            step;
        end
        drain("r34_drain");

        // Pause while streaming.
        apply_reset;
        for (int i = 1; i <= 6; i++) load(0, 6'(i));
        reset = 1'b1;
        #1;
        check("r35_pop_c0", 32'(bus.pop_vc0), 32'd1);
        step;
        check("r35_pop_c1", 32'(bus.pop_vc0), 32'd1);
        step;
        bus.pause_d1 = 1'b1;
        #1;
        check("r35_stop",   32'({bus.pop_vc1, bus.pop_vc0}), 32'd0);
        check("r35_push_a", 32'({bus.push_d1, bus.push_d0}), 32'b01);
        check("r35_data_a", 32'(bus.data_out_d0), 32'h01);
        step;
        check("r35_pause",  32'(state), 32'd2);
        check("r35_push_b", 32'({bus.push_d1, bus.push_d0}), 32'b01);
        check("r35_data_b", 32'(bus.data_out_d0), 32'h02);
        check("r35_held",   32'({bus.pop_vc1, bus.pop_vc0}), 32'd0);
        step;
        check("r35_nopush", 32'({bus.push_d1, bus.push_d0}), 32'd0);
        bus.pause_d1 = 1'b0;
        #1;
        check("r35_rel_cyc", 32'({bus.pop_vc1, bus.pop_vc0}), 32'd0);
        step;
        check("r35_active", 32'(state), 32'd1);
        check("r35_resume", 32'(bus.pop_vc0), 32'd1);
        drain("r35_drain");

        // Pause arriving with the first word wins; then single VC1 word.
        bus.pause_d0 = 1'b1;
        load(1, 6'h3A);
        #1;
        check("r27_nopop", 32'({bus.pop_vc1, bus.pop_vc0}), 32'd0);
        step;
        check("r27_idle", 32'(state), 32'd0);
        bus.pause_d0 = 1'b0;
        #1;
        check("r36_pop", 32'({bus.pop_vc1, bus.pop_vc0}), 32'b10);
        step;
        check("r36_nopop", 32'({bus.pop_vc1, bus.pop_vc0}), 32'd0);
        check("r36_busy1", 32'(idle_out), 32'd0);
        step;
        check("r36_push",  32'({bus.push_d1, bus.push_d0}), 32'b10);
        check("r36_data",  32'(bus.data_out_d1), 32'h3A);
        check("r36_busy2", 32'(idle_out), 32'd0);
        step;
        check("r36_idle",  32'(idle_out), 32'd1);

        // Reset the cycle after a pop drops the in-flight word.
        load(0, 6'h0B);
        #1;
        check("r37_pop", 32'(bus.pop_vc0), 32'd1);
        step;
        reset = 1'b0;
        #1;
        check("r37_push",  32'({bus.push_d1, bus.push_d0}), 32'd0);
        check("r37_dout0", 32'(bus.data_out_d0), 32'd0);
        check("r37_dout1", 32'(bus.data_out_d1), 32'd0);
        check("r37_state", 32'(state), 32'd0);
        check("r37_idle",  32'(idle_out), 32'd1);
        check("r37_pops",  32'({bus.pop_vc1, bus.pop_vc0}), 32'd0);
        step;
        reset = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("r37_quiet_c%0d", c), 32'({bus.push_d1, bus.push_d0}), 32'd0);
            step;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
